video_cfg_sequencer: RTL and testbench
======================================

VIDEO_CFG_SEQUENCER -- requirements
Module: video_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter VS_POL, default 1'b0, meaning the active VSync level (0 = active-low).
REQ-002 The block SHALL have parameter MUTE_FRAMES, default 2, meaning the number of VSync leading edges the output stays muted after a config apply (range 1-15).
REQ-003 The block SHALL have parameter TIMEOUT_W, default 22, meaning the width of the missing-VSync watchdog counter.
REQ-004 The block SHALL have parameter RESET_CFG, default 12'h000, meaning the value of cfg_active after reset.
REQ-005 The block SHALL have port clk_sys, input, width 1: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port cfg_req, input, width 12: the requested config {blend_coeff[3:0], blend, rotate[1:0], ypbpr, no_csync, scandoubler_disable, scanlines[1:0]}, with bit 0 as the LSB of scanlines.
REQ-008 The block SHALL have port vsync, input, width 1: the core VSync, synchronous to clk_sys.
REQ-009 The block SHALL have port cfg_active, output, width 12: the registered config driven to the video pipeline, in the same field layout as cfg_req.
REQ-010 The block SHALL have port mute, output, width 1: forces the pipeline RGB to black when high.
REQ-011 The block SHALL have port busy, output, width 1: high in every state except IDLE.
REQ-012 The block SHALL have port apply_cnt, output, width 8: a wrapping count of completed applies.

Function
REQ-013 The block SHALL implement states IDLE, WAIT_VS, APPLY and SETTLE.
REQ-014 A VSync leading edge SHALL be one cycle where vsync==VS_POL and the previous-cycle sample of vsync was !VS_POL.
REQ-015 IDLE: when cfg_req!=cfg_active, the block SHALL capture cfg_req into cfg_pend and move to WAIT_VS on the next cycle.
REQ-016 WAIT_VS: the block SHALL load cfg_pend from cfg_req every cycle, so the latest request wins, and SHALL hold mute unchanged.
REQ-017 WAIT_VS: on a VSync leading edge or watchdog expiry, the block SHALL set mute=1 and go to APPLY.
REQ-018 APPLY: the block SHALL last exactly one cycle, SHALL load cfg_active<=cfg_pend, SHALL increment apply_cnt modulo 256, SHALL clear the frame counter to 0, and SHALL go to SETTLE.
REQ-019 SETTLE: each VSync leading edge SHALL increment the frame counter; when the counter reaches MUTE_FRAMES, the block SHALL clear mute in that same cycle and go to IDLE.
REQ-020 SETTLE: if cfg_req!=cfg_active on a VSync leading edge, the block SHALL capture cfg_req into cfg_pend and go to APPLY, keeping mute=1; that edge SHALL NOT count as a frame.
REQ-021 SETTLE: a cfg_req change between edges SHALL take effect only when sampled at the next edge.
REQ-022 Watchdog: the counter SHALL clear on every VSync leading edge and on every state change, SHALL count in WAIT_VS and SETTLE, and SHALL expire at all-ones.
REQ-023 In SETTLE, watchdog expiry SHALL be treated as a VSync leading edge for frame counting, so a missing VSync cannot leave mute stuck high.
REQ-024 The block SHALL change cfg_active only in APPLY, so every config field switches atomically in a single cycle.
REQ-025 The latency from a VSync leading edge in WAIT_VS to the cfg_active update SHALL be 2 cycles: edge cycle, then APPLY.
REQ-026 A cfg_req change that reverts to cfg_active before WAIT_VS sees an edge SHALL still complete the sequence, applying the identical value and incrementing apply_cnt.

Reset
REQ-027 On reset_n low, the block SHALL asynchronously set state=WAIT_VS, mute=1, busy=1, cfg_active=RESET_CFG, cfg_pend=RESET_CFG, apply_cnt=0, the frame counter to 0, the watchdog to 0, and the vsync history to !VS_POL.
REQ-028 After reset release, the first VSync leading edge or watchdog expiry SHALL apply the then-current cfg_req.
REQ-029 Reset asserted in any state, including mid-APPLY, SHALL override all other behaviour.

Structure
REQ-030 The field offsets and widths of the cfg bundle, CFG_W=12, and the state encodings SHALL live in a shared package, video_cfg_pkg, which is also used by the pipeline top.
REQ-031 VSync edge detection together with the watchdog SHALL be one sub-module, video_vs_watch, with outputs vs_edge and timeout, giving a single-cycle pulse for each.

Verification
REQ-032 Reset with cfg_req=12'h005 (RESET_CFG=0), then a VSync edge, SHALL give cfg_active=12'h005 two cycles later, with mute=0 exactly 2 further VSync edges later and apply_cnt=1.
REQ-033 In IDLE, changing scanlines 0->2 and then 2->3 before the edge SHALL apply only 3, with apply_cnt incrementing once.
REQ-034 In SETTLE after the first of two frames, toggling ypbpr SHALL cause a re-apply at the next edge, keep mute high continuously, and require 2 more edges before mute=0.
REQ-035 With TIMEOUT_W=8 and vsync held inactive, a cfg change SHALL apply 256 cycles after WAIT_VS entry, and mute SHALL clear after 2 further timeouts.
REQ-036 Pulsing reset_n low during APPLY SHALL set cfg_active=RESET_CFG, mute=1 and state=WAIT_VS immediately, without waiting for a clock.
REQ-037 With VS_POL=1 and an active-high vsync, a change SHALL apply only on rising edges; falling edges SHALL be ignored.

Source files
------------

// File: rtl/video_cfg_pkg.sv
// rtl/video_cfg_pkg.sv - cfg bundle layout and sequencer state encoding shared with the video pipeline
package video_cfg_pkg;

  // Declared MSB first, so scanlines[0] lands on bit 0 of the 12-bit bundle.
  typedef struct packed {
    logic [3:0] blend_coeff;
    logic       blend;
    logic [1:0] rotate;
    logic       ypbpr;
    logic       no_csync;
    logic       scandoubler_disable;
    logic [1:0] scanlines;
  } cfg_t;

  localparam int CFG_W = $bits(cfg_t);

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_WAIT_VS = 2'd1,
    SEQ_APPLY   = 2'd2,
    SEQ_SETTLE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/video_vs_watch.sv
// rtl/video_vs_watch.sv - VSync leading-edge detector plus missing-VSync watchdog
module video_vs_watch #(
  parameter logic VS_POL    = 1'b0,
  parameter int   TIMEOUT_W = 22
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic vsync,
  input  logic count_en,
  input  logic restart,
  output logic vs_edge,
  output logic timeout
);

  logic                 vs_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [TIMEOUT_W-1:0] wd_d;

  assign vs_edge = (vsync == VS_POL) && (vs_q != VS_POL);
  assign timeout = count_en && (&wd_q);

  // Expiry lets the counter wrap to zero, so a dead VSync keeps producing evenly spaced timeouts.
  always_comb begin
    wd_d = wd_q;
    if (vs_edge || restart) begin
      wd_d = '0;
    end else if (count_en) begin
      wd_d = wd_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= ~VS_POL;
      wd_q <= '0;
    end else begin
      vs_q <= vsync;
      wd_q <= wd_d;
    end
  end

endmodule

// File: rtl/video_cfg_sequencer.sv
// rtl/video_cfg_sequencer.sv - applies video config changes atomically at VSync with output muting
module video_cfg_sequencer
  import video_cfg_pkg::*;
#(
  parameter logic             VS_POL      = 1'b0,
  parameter int               MUTE_FRAMES = 2,
  parameter int               TIMEOUT_W   = 22,
  parameter logic [CFG_W-1:0] RESET_CFG   = 12'h000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  cfg_t       cfg_req,
  input  logic       vsync,
  output cfg_t       cfg_active,
  output logic       mute,
  output logic       busy,
  output logic [7:0] apply_cnt
);

  seq_state_e state_q, state_d;
  cfg_t       active_q, active_d;
  cfg_t       pend_q, pend_d;
  logic       mute_q, mute_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] frame_q, frame_d;

  logic vs_edge;
  logic timeout;
  logic frame_evt;
  logic count_en;

  assign count_en  = (state_q == SEQ_WAIT_VS) || (state_q == SEQ_SETTLE);
  assign frame_evt = vs_edge || timeout;

  video_vs_watch #(
    .VS_POL   (VS_POL),
    .TIMEOUT_W(TIMEOUT_W)
  ) u_vs_watch (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vsync   (vsync),
    .count_en(count_en),
    .restart (state_d != state_q),
    .vs_edge (vs_edge),
    .timeout (timeout)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pend_d   = pend_q;
    mute_d   = mute_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (cfg_req != active_q) begin
          pend_d  = cfg_req;
          state_d = SEQ_WAIT_VS;
        end
      end
      SEQ_WAIT_VS: begin
        pend_d = cfg_req;
        if (frame_evt) begin
          mute_d  = 1'b1;
          state_d = SEQ_APPLY;
        end
      end
      SEQ_APPLY: begin
        active_d = pend_q;
        cnt_d    = cnt_q + 8'd1;
        frame_d  = 4'd0;
        state_d  = SEQ_SETTLE;
      end
      SEQ_SETTLE: begin
        // A new request seen on a real edge restarts the mute window instead of counting a frame.
        if (vs_edge && (cfg_req != active_q)) begin
          pend_d  = cfg_req;
          state_d = SEQ_APPLY;
        end else if (frame_evt) begin
          frame_d = frame_q + 4'd1;
          if (frame_d == 4'(MUTE_FRAMES)) begin
            mute_d  = 1'b0;
            state_d = SEQ_IDLE;
          end
        end
      end
      default: state_d = SEQ_WAIT_VS;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEQ_WAIT_VS;
      active_q <= RESET_CFG;
      pend_q   <= RESET_CFG;
      mute_q   <= 1'b1;
      cnt_q    <= 8'd0;
      frame_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      mute_q   <= mute_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
    end
  end

  assign cfg_active = active_q;
  assign mute       = mute_q;
  assign busy       = (state_q != SEQ_IDLE);
  assign apply_cnt  = cnt_q;

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// tb/tb_video_cfg_sequencer.sv - self-checking bench for video_cfg_sequencer
module tb_video_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [11:0] cfg_req = 12'h005;
  logic        vsync = 1'b1;
  logic        vsync_hi;

  logic [11:0] act0, act1;
  logic        mute0, mute1, busy0, busy1;
  logic [7:0]  cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  assign vsync_hi = ~vsync;

  always #5 clk = ~clk;

  video_cfg_sequencer #(
    .VS_POL(1'b0), .MUTE_FRAMES(2), .TIMEOUT_W(8), .RESET_CFG(12'h000)
  ) dut0 (
    .clk_sys(clk), .reset_n(reset_n), .cfg_req(cfg_req), .vsync(vsync),
    .cfg_active(act0), .mute(mute0), .busy(busy0), .apply_cnt(cnt0)
  );

  video_cfg_sequencer #(
    .VS_POL(1'b1), .MUTE_FRAMES(2), .TIMEOUT_W(8), .RESET_CFG(12'h000)
  ) dut1 (
    .clk_sys(clk), .reset_n(reset_n), .cfg_req(cfg_req), .vsync(vsync_hi),
    .cfg_active(act1), .mute(mute1), .busy(busy1), .apply_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Behavioural model: "waiting" means a change is pending and no frame boundary has come yet,
  // "applying" is the one cycle in which the new config lands, "settling" counts muted frames.
  localparam int PH_IDLE = 0, PH_WAITING = 1, PH_APPLYING = 2, PH_SETTLING = 3;
  int          m_phase;
  logic [11:0] m_active, m_pend;
  logic        m_mute;
  int          m_applies;
  int          m_frames_seen;
  int          m_quiet_cycles;
  logic        m_prev_vs;

  task automatic model_reset();
    m_phase = PH_WAITING; m_active = 12'h000; m_pend = 12'h000; m_mute = 1'b1;
    m_applies = 0; m_frames_seen = 0; m_quiet_cycles = 0; m_prev_vs = 1'b1;
  endtask

  task automatic model_step(input logic [11:0] req, input logic vs);
    bit frame_start = (vs == 1'b0) && (m_prev_vs == 1'b1);
    bit watching    = (m_phase == PH_WAITING) || (m_phase == PH_SETTLING);
    bit starved     = watching && (m_quiet_cycles == 255);
    int nxt = m_phase;
    if (m_phase == PH_IDLE) begin
      if (req != m_active) begin m_pend = req; nxt = PH_WAITING; end
    end else if (m_phase == PH_WAITING) begin
      m_pend = req;
      if (frame_start || starved) begin m_mute = 1'b1; nxt = PH_APPLYING; end
    end else if (m_phase == PH_APPLYING) begin
      m_active = m_pend; m_applies = (m_applies + 1) % 256; m_frames_seen = 0; nxt = PH_SETTLING;
    end else begin
      if (frame_start && req != m_active) begin
        m_pend = req; nxt = PH_APPLYING;
      end else if (frame_start || starved) begin
        m_frames_seen++;
        if (m_frames_seen == 2) begin m_mute = 1'b0; nxt = PH_IDLE; end
      end
    end
    if (frame_start || nxt != m_phase) m_quiet_cycles = 0;
    else if (watching) m_quiet_cycles = (m_quiet_cycles + 1) % 256;
    m_phase = nxt;
    m_prev_vs = vs;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) model_reset();
    chk("cyc_cfg_active0", act0, m_active);
    chk("cyc_mute0", mute0, m_mute);
    chk("cyc_busy0", busy0, m_phase != PH_IDLE);
    chk("cyc_apply_cnt0", cnt0, m_applies);
    chk("cyc_cfg_active1", act1, m_active);
    chk("cyc_mute1", mute1, m_mute);
    chk("cyc_busy1", busy1, m_phase != PH_IDLE);
    chk("cyc_apply_cnt1", cnt1, m_applies);
    if (reset_n) model_step(cfg_req, vsync);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle low pulse on the active-low vsync; returns just after the edge cycle is clocked.
  task automatic vs_fall();
    vsync = 1'b0;
    @(posedge clk);
    #1;
    vsync = 1'b1;
  endtask

  task automatic settle2();
    tick(5); vs_fall();
    tick(5); vs_fall();
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("reset_cfg_active", act0, 12'h000);
    chk("reset_mute", mute0, 1'b1);
    chk("reset_busy", busy0, 1'b1);
    chk("reset_apply_cnt", cnt0, 8'd0);
    tick(2);
    reset_n = 1'b1;

    // First edge after reset applies cfg_req two cycles later, unmute after two more edges
    tick(3); vs_fall();
    chk("first_apply_not_yet", act0, 12'h000);
    tick(1);
    chk("first_apply_cfg", act0, 12'h005);
    chk("first_apply_cnt", cnt0, 8'd1);
    tick(5); vs_fall();
    chk("first_settle_mute_held", mute0, 1'b1);
    tick(5); vs_fall();
    chk("first_settle_unmute", mute0, 1'b0);
    chk("first_settle_idle", busy0, 1'b0);
    chk("first_settle_cnt", cnt0, 8'd1);

    // Scanlines 0, then 2 -> 3 before the edge: only 3 lands, one apply
    cfg_req = 12'h004;
    tick(3); vs_fall(); tick(1);
    chk("scan0_cfg", act0, 12'h004);
    settle2();
    cfg_req = 12'h006;
    tick(3);
    chk("wait_mute_held_low", mute0, 1'b0);
    chk("wait_busy", busy0, 1'b1);
    cfg_req = 12'h007;
    tick(3); vs_fall(); tick(1);
    chk("latest_wins_cfg", act0, 12'h007);
    chk("latest_wins_cnt", cnt0, 8'd3);
    settle2();

    // Toggle ypbpr mid-SETTLE: re-apply at next edge, mute stays high, two more edges needed
    cfg_req = 12'h8A7;
    tick(3); vs_fall(); tick(1);
    chk("blend_cfg", act0, 12'h8A7);
    tick(5); vs_fall();
    cfg_req = 12'h8B7;
    tick(3);
    chk("settle_change_deferred", act0, 12'h8A7);
    vs_fall(); tick(1);
    chk("reapply_cfg", act0, 12'h8B7);
    chk("reapply_cnt", cnt0, 8'd5);
    chk("reapply_mute", mute0, 1'b1);
    tick(5); vs_fall();
    chk("reapply_mute_frame1", mute0, 1'b1);
    tick(5); vs_fall();
    chk("reapply_unmute", mute0, 1'b0);

    // A request that reverts before the edge still completes and counts
    cfg_req = 12'h8B4;
    tick(2);
    cfg_req = 12'h8B7;
    tick(3); vs_fall(); tick(1);
    chk("revert_cfg", act0, 12'h8B7);
    chk("revert_cnt", cnt0, 8'd6);
    settle2();

    // Missing vsync: watchdog applies 256 cycles after WAIT_VS entry, two more timeouts unmute
    cfg_req = 12'h123;
    tick(257);
    chk("timeout_before_apply", act0, 12'h8B7);
    tick(1);
    chk("timeout_apply_cfg", act0, 12'h123);
    chk("timeout_apply_cnt", cnt0, 8'd7);
    tick(511);
    chk("timeout_still_muted", mute0, 1'b1);
    tick(1);
    chk("timeout_unmute", mute0, 1'b0);
    chk("timeout_idle", busy0, 1'b0);

    // Active-high instance: falling edge of its vsync ignored, rising edge applies
    vsync = 1'b0;
    tick(3);
    cfg_req = 12'h456;
    tick(3);
    vsync = 1'b1;
    tick(3);
    chk("pol_hi_fall_ignored", act1, 12'h123);
    chk("pol_hi_busy", busy1, 1'b1);
    vsync = 1'b0;
    tick(2);
    chk("pol_hi_rise_applies", act1, 12'h456);
    chk("pol_hi_cnt", cnt1, 8'd8);
    vsync = 1'b1;
    settle2();

    // Reset pulse during APPLY takes effect without a clock
    cfg_req = 12'h789;
    tick(3); vs_fall();
    #1 reset_n = 1'b0;
    #1;
    chk("apply_reset_cfg", act0, 12'h000);
    chk("apply_reset_mute", mute0, 1'b1);
    chk("apply_reset_busy", busy0, 1'b1);
    chk("apply_reset_cnt", cnt0, 8'd0);
    chk("apply_reset_cfg_hi", act1, 12'h000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(3); vs_fall(); tick(1);
    chk("post_reset_apply_cfg", act0, 12'h789);
    chk("post_reset_apply_cnt", cnt0, 8'd1);
    settle2();
    chk("post_reset_unmute", mute0, 1'b0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
